pixel_stream_feeder: RTL and testbench

- Transmitter for the sorting network's pixel input. It reads one RGB888 frame from a synchronous-read image memory in raster order.
- Drives the pixel bus with a valid/ready handshake and generates the conv_start window the network expects.
- Appends a zero-pixel tail so the convolution pipeline flushes before conv_start drops.
- Sits between the frame buffer BRAM and the network's d_in and conv_start inputs.

---
 rtl/pixel_feeder_pkg.sv | 29 ++
 rtl/pix_skid_fifo.sv | 67 ++++++
 rtl/pixel_stream_feeder.sv | 138 +++++++++++++
 tb/tb_pixel_stream_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_feeder_pkg.sv
// Shared types and helpers for the pixel stream feeder.
package pixel_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } feeder_state_e;

   localparam int IMG_W_DEF = 32;
   localparam int IMG_H_DEF = 32;
   localparam int FRAME_PIX = IMG_W_DEF * IMG_H_DEF;

   // Bits needed to hold values 0..v-1 (never less than 1).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int frame_pix(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry first-word-fall-through FIFO holding pixels returned by the memory.
module pix_skid_fifo
   import pixel_feeder_pkg::*;
#(
   parameter int PIX_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [PIX_W-1:0] push_data,
   input  logic             pop,
   output logic [PIX_W-1:0] head,
   output logic             empty,
   output logic [1:0]       count
);

   logic [PIX_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             pop_ok, push_ok;

   // Next entry contents and occupancy for every push/pop combination.
   always_comb begin
      pop_ok  = pop & (cnt_q != 2'd0);
      push_ok = push & ((cnt_q != 2'd2) | pop_ok);
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      cnt_d   = cnt_q;
      case ({push_ok, pop_ok})
         2'b10: begin
            if (cnt_q == 2'd0) ent0_d = push_data;
            else               ent1_d = push_data;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               ent0_d = push_data;
            end else begin
               ent0_d = ent1_q;
               ent1_d = push_data;
            end
         end
         default: ;
      endcase
   end

   // Storage and occupancy registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign head  = ent0_q;
   assign empty = (cnt_q == 2'd0);
   assign count = cnt_q;

endmodule

// File: rtl/pixel_stream_feeder.sv
// Reads one frame from image memory in raster order and streams it to the
// sorting network with valid/ready, followed by a zero-pixel flush tail.
module pixel_stream_feeder
   import pixel_feeder_pkg::*;
#(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int ADDR_W = 10,
   parameter int PIX_W  = 24,
   parameter int TAIL   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic [PIX_W-1:0]  d_out,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              conv_start,
   output logic              busy,
   output logic              frame_done
);

   localparam int NPIX = frame_pix(IMG_W, IMG_H);
   localparam int CW   = clog2(NPIX + 1);
   localparam int TW   = clog2(TAIL + 1);
   localparam logic [CW-1:0] NPIX_C    = CW'(NPIX);
   localparam logic [CW-1:0] LAST_C    = CW'(NPIX - 1);
   localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL - 1);

   feeder_state_e     state_q, state_d;
   logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
   logic [TW-1:0]     tail_cnt_q, tail_cnt_d;
   logic              inflight_q, inflight_d;
   logic              started_q, started_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   logic [PIX_W-1:0]  fifo_head;
   logic              fifo_empty;
   logic [1:0]        fifo_count;
   logic              fifo_pop;
   logic              stream_vld;
   logic              beat;
   logic              issue;
   logic [2:0]        credit_used;

   pix_skid_fifo #(.PIX_W(PIX_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data (mem_rdata),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Output decode from registered state and FIFO occupancy only. A read may
   // be issued with two words outstanding when the head leaves this cycle;
   // without that credit the one-cycle read latency would halve throughput.
   always_comb begin
      stream_vld  = (state_q == STREAM) && !fifo_empty;
      pix_valid   = stream_vld || (state_q == DRAIN);
      d_out       = stream_vld ? fifo_head : '0;
      conv_start  = ((state_q == STREAM) && (started_q || !fifo_empty)) ||
                    (state_q == DRAIN);
      busy        = (state_q != IDLE);
      frame_done  = (state_q == DONE);
      beat        = pix_valid && pix_ready;
      fifo_pop    = stream_vld && pix_ready;
      credit_used = {1'b0, fifo_count} + {2'b00, inflight_q};
      issue       = (state_q == STREAM) && (rd_cnt_q < NPIX_C) &&
                    (credit_used < (3'd2 + {2'b00, fifo_pop}));
      mem_en      = issue;
      mem_addr    = issue ? ADDR_W'(rd_cnt_q) : addr_q;
   end

   // Frame sequencing: counters and next state.
   always_comb begin
      state_d    = state_q;
      rd_cnt_d   = rd_cnt_q;
      tx_cnt_d   = tx_cnt_q;
      tail_cnt_d = tail_cnt_q;
      started_d  = started_q;
      inflight_d = issue;
      addr_d     = mem_addr;
      case (state_q)
         IDLE: begin
            rd_cnt_d   = '0;
            tx_cnt_d   = '0;
            tail_cnt_d = '0;
            started_d  = 1'b0;
            if (frame_req) state_d = STREAM;
         end
         STREAM: begin
            if (issue)       rd_cnt_d  = rd_cnt_q + CW'(1);
            if (!fifo_empty) started_d = 1'b1;
            if (beat) begin
               tx_cnt_d = tx_cnt_q + CW'(1);
               if (tx_cnt_q == LAST_C) state_d = (TAIL == 0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (pix_ready) begin
               if (tail_cnt_q == TAIL_LAST) state_d = DONE;
               else                         tail_cnt_d = tail_cnt_q + TW'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control registers; reset aborts the frame and drops any in-flight read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         rd_cnt_q   <= '0;
         tx_cnt_q   <= '0;
         tail_cnt_q <= '0;
         inflight_q <= 1'b0;
         started_q  <= 1'b0;
         addr_q     <= '0;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         tx_cnt_q   <= tx_cnt_d;
         tail_cnt_q <= tail_cnt_d;
         inflight_q <= inflight_d;
         started_q  <= started_d;
         addr_q     <= addr_d;
      end
   end

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Bench for pixel_stream_feeder: a 4x2/TAIL=3 instance driven from a scenario
// table with an expected-pixel queue, plus a 1x1/TAIL=0 instance by hand.
module tb_pixel_stream_feeder;

   localparam int NA     = 8;
   localparam int TAIL_A = 3;

   logic        clk;
   logic        rst;
   int          pat;
   int          checks;
   int          errors;
   int          rpat [6];

   logic        fr_a, rdy_a, en_a, val_a, conv_a, busy_a, done_a;
   logic [2:0]  addr_a;
   logic [23:0] rdata_a, dout_a;

   logic        fr_b, rdy_b, en_b, val_b, conv_b, busy_b, done_b;
   logic [0:0]  addr_b;
   logic [23:0] rdata_b, dout_b;

   pixel_stream_feeder #(.IMG_W(4), .IMG_H(2), .ADDR_W(3), .PIX_W(24), .TAIL(TAIL_A)) dut_a (
      .clk(clk), .rst(rst), .frame_req(fr_a), .mem_addr(addr_a), .mem_en(en_a),
      .mem_rdata(rdata_a), .d_out(dout_a), .pix_valid(val_a), .pix_ready(rdy_a),
      .conv_start(conv_a), .busy(busy_a), .frame_done(done_a)
   );

   pixel_stream_feeder #(.IMG_W(1), .IMG_H(1), .ADDR_W(1), .PIX_W(24), .TAIL(0)) dut_b (
      .clk(clk), .rst(rst), .frame_req(fr_b), .mem_addr(addr_b), .mem_en(en_b),
      .mem_rdata(rdata_b), .d_out(dout_b), .pix_valid(val_b), .pix_ready(rdy_b),
      .conv_start(conv_b), .busy(busy_b), .frame_done(done_b)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] mem_word(input int a);
      if (pat == 0) return 24'(a);
      return 24'((a * 32'h000f1d2b) ^ (pat * 32'h00539a17));
   endfunction

   // Synchronous-read memories with one cycle of latency.
   always @(posedge clk) if (en_a) rdata_a <= mem_word(int'(addr_a));
   always @(posedge clk) if (en_b) rdata_b <= mem_word(int'(addr_b));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      int mode;       // 0 ready high, 1 fixed toggle pattern, 2 random
      int req_again;  // cycle of a second frame_req, -1 none
      int rst_at;     // beats after which reset is pulsed, -1 none
      int pat;        // memory content pattern
      int exp_beats;
      int exp_done;
      int exp_conv;   // conv_start high cycles, -1 unchecked
   } vec_t;

   task automatic run_a(input vec_t v);
      int   exp_q[$];
      int   beats, issued, conv_cnt, done_cnt, first_v, last_b, cyc, streamed;
      bit   prev_hold, finished, rst_now;
      logic [23:0] prev_d;
      for (int i = 0; i < NA; i++) exp_q.push_back(int'(mem_word(i)));
      for (int i = 0; i < TAIL_A; i++) exp_q.push_back(0);
      beats = 0; issued = 0; conv_cnt = 0; done_cnt = 0;
      first_v = -1; last_b = -1; prev_hold = 0; prev_d = '0; finished = 0;
      for (cyc = 0; cyc < 300 && !finished; cyc++) begin
         fr_a = (cyc == 0) || (cyc == v.req_again);
         case (v.mode)
            0:       rdy_a = 1'b1;
            1:       rdy_a = rpat[cyc % 6] != 0;
            default: rdy_a = 1'($urandom_range(0, 1));
         endcase
         rst_now = (v.rst_at >= 0) && (beats >= v.rst_at);
         rst = !rst_now;
         @(negedge clk);
         if (val_a && first_v < 0) first_v = cyc;
         if (prev_hold) begin
            chk("hold_valid", val_a, 1);
            chk("hold_data", dout_a, prev_d);
         end
         if (val_a && rdy_a) begin
            if (beats < exp_q.size()) chk("d_out", dout_a, exp_q[beats]);
            else                      chk("extra_beat", 1, 0);
            beats++;
            if (beats == exp_q.size()) last_b = cyc;
         end
         streamed = (beats < NA) ? beats : NA;
         if (en_a) begin
            chk("mem_addr", addr_a, issued);
            issued++;
            chk("read_past_end", issued <= NA, 1);
            chk("outstanding_le2", (issued - streamed) <= 2, 1);
         end
         chk("conv_start", conv_a, (first_v >= 0) && (last_b < 0 || cyc == last_b));
         chk("frame_done", done_a, (last_b >= 0) && (cyc == last_b + 1));
         if (conv_a) conv_cnt++;
         if (done_a) done_cnt++;
         prev_hold = val_a && !rdy_a;
         prev_d    = dout_a;
         if (last_b >= 0 && cyc > last_b + 1) begin
            chk("busy_after_done", busy_a, 0);
            finished = 1;
         end
         @(posedge clk); #1;
         if (rst_now) begin
            rst  = 1'b1;
            fr_a = 1'b0;
            @(negedge clk);
            chk("rst_mem_addr", addr_a, 0);
            chk("rst_mem_en", en_a, 0);
            chk("rst_d_out", dout_a, 0);
            chk("rst_valid", val_a, 0);
            chk("rst_conv", conv_a, 0);
            chk("rst_busy", busy_a, 0);
            chk("rst_done", done_a, 0);
            @(posedge clk); #1;
            finished = 1;
         end
      end
      fr_a = 1'b0;
      rst  = 1'b1;
      chk("frame_timeout", finished, 1);
      chk("beat_count", beats, v.exp_beats);
      // Stays idle: a late or mid-frame request must not start another frame.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_busy", busy_a, 0);
         chk("idle_valid", val_a, 0);
         chk("idle_done", done_a, 0);
         @(posedge clk); #1;
      end
      chk("done_count", done_cnt, v.exp_done);
      if (v.exp_conv >= 0) chk("conv_cycles", conv_cnt, v.exp_conv);
      if (v.mode == 0 && v.rst_at < 0) begin
         chk("first_valid_latency", first_v, 3);
         chk("back_to_back", last_b - first_v, NA + TAIL_A - 1);
      end
   endtask

   vec_t vecs [8];

   initial begin
      clk = 0; rst = 0; pat = 0;
      fr_a = 0; rdy_a = 0; fr_b = 0; rdy_b = 0;
      checks = 0; errors = 0;
      rpat = '{1, 0, 0, 1, 0, 1};
      vecs[0] = '{0, -1, -1, 0, 11, 1, 11};
      vecs[1] = '{1, -1, -1, 3, 11, 1, -1};
      vecs[2] = '{2, -1, -1, 7, 11, 1, -1};
      vecs[3] = '{0,  5, -1, 9, 11, 1, 11};
      vecs[4] = '{0, 14, -1, 0, 11, 1, 11};
      vecs[5] = '{0, -1,  3, 0,  4, 0, -1};
      vecs[6] = '{0, -1, -1, 0, 11, 1, 11};
      vecs[7] = '{2,  6, -1, 11, 11, 1, -1};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_mem_addr", addr_a, 0);
      chk("reset_mem_en", en_a, 0);
      chk("reset_d_out", dout_a, 0);
      chk("reset_valid", val_a, 0);
      chk("reset_conv", conv_a, 0);
      chk("reset_busy", busy_a, 0);
      chk("reset_done", done_a, 0);
      chk("reset_b_valid", val_b, 0);
      @(posedge clk); #1;
      rst = 1;

      for (int r = 0; r < 8; r++) begin
         pat = vecs[r].pat;
         run_a(vecs[r]);
      end

      // Single-pixel frame, no tail, ready high.
      pat = 5;
      rdy_b = 1'b1;
      for (int c = 0; c < 7; c++) begin
         fr_b = (c == 0);
         @(negedge clk);
         chk("b_mem_en", en_b, c == 1);
         chk("b_valid", val_b, c == 3);
         chk("b_conv", conv_b, c == 3);
         chk("b_done", done_b, c == 4);
         chk("b_busy", busy_b, (c >= 1) && (c <= 4));
         if (c == 3) chk("b_d_out", dout_b, mem_word(0));
         @(posedge clk); #1;
      end

      // Single-pixel frame held off by ready low for two valid cycles.
      pat = 2;
      for (int c = 0; c < 8; c++) begin
         fr_b  = (c == 0);
         rdy_b = (c >= 5);
         @(negedge clk);
         chk("b2_valid", val_b, (c >= 3) && (c <= 5));
         chk("b2_conv", conv_b, (c >= 3) && (c <= 5));
         chk("b2_done", done_b, c == 6);
         if (c >= 3 && c <= 5) chk("b2_d_out", dout_b, mem_word(0));
         @(posedge clk); #1;
      end
      fr_b = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
